// File: rtl/traffic_phase_ctrl_if.sv
// Bundle between the phase controller and its environment (counter + top).
// The master side is the controller; the slave side is whoever drives run,
// pedestrian requests and the counter status.
interface traffic_phase_ctrl_if #(
  parameter int pCNT_WIDTH = 5
);
  logic                  run;
  logic                  ped_req;
  logic                  cnt_last;
  logic [pCNT_WIDTH-1:0] cnt_val;
  logic [2:0]            cnt_init;
  logic                  cnt_en;
  logic [2:0]            light_out;
  logic                  ped_walk;
  logic                  ped_pend;

  modport master (
    input  run, ped_req, cnt_last, cnt_val,
    output cnt_init, cnt_en, light_out, ped_walk, ped_pend
  );

  modport slave (
    output run, ped_req, cnt_last, cnt_val,
    input  cnt_init, cnt_en, light_out, ped_walk, ped_pend
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Moore phase sequencer for one light_counter: RED -> GREEN -> YELLOW -> RED,
// with pedestrian green shortening and a flashing-yellow maintenance mode.
// Every output is registered from the next state, so output values always
// line up with the state held in state_q.
module traffic_phase_ctrl #(
  parameter int pCNT_WIDTH     = 5,
  parameter int pPED_MIN_GREEN = 4,
  parameter int pFLASH_HALF    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_phase_ctrl_if.master  bus_if
);

  typedef enum logic [2:0] {
    IDLE, LOAD_R, RED, LOAD_G, GREEN, LOAD_Y, YELLOW, FLASH
  } state_t;

  localparam logic [pCNT_WIDTH-1:0] PED_MIN    = pCNT_WIDTH'(pPED_MIN_GREEN);
  localparam logic [7:0]            FLASH_LAST = 8'(pFLASH_HALF - 1);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  state_t     state_q, state_d;
  logic [2:0] cnt_init_q, cnt_init_d;
  logic       cnt_en_q, cnt_en_d;
  logic [2:0] light_q, light_d;
  logic       walk_q, walk_d;
  logic       pend_q, pend_d;
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic       flash_ph_q, flash_ph_d;

  // Next-state selection; dropping run overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus_if.run ? LOAD_R : FLASH;
      LOAD_R:  state_d = RED;
      RED:     if (bus_if.cnt_last) state_d = LOAD_G;
      LOAD_G:  state_d = GREEN;
      GREEN:   if (bus_if.cnt_last || (pend_q && (bus_if.cnt_val > PED_MIN)))
                 state_d = LOAD_Y;
      LOAD_Y:  state_d = YELLOW;
      YELLOW:  if (bus_if.cnt_last) state_d = LOAD_R;
      FLASH:   if (bus_if.run) state_d = LOAD_R;
      default: state_d = IDLE;
    endcase
    if (!bus_if.run && (state_q != FLASH)) state_d = FLASH;
  end

  // Registered-output values derived from the state being entered.
  always_comb begin
    cnt_init_d  = 3'b000;
    cnt_en_d    = 1'b0;
    light_d     = LAMP_RED;
    walk_d      = 1'b0;
    pend_d      = pend_q;
    flash_cnt_d = 8'd0;
    flash_ph_d  = 1'b0;

    // Flash timer only advances while staying in FLASH; entry restarts it lit.
    if ((state_d == FLASH) && (state_q == FLASH)) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d = 8'd0;
        flash_ph_d  = ~flash_ph_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 8'd1;
        flash_ph_d  = flash_ph_q;
      end
    end

    unique case (state_d)
      IDLE:    light_d = LAMP_RED;
      LOAD_R:  begin light_d = LAMP_RED; cnt_init_d = 3'b100; walk_d = 1'b1; end
      RED:     begin light_d = LAMP_RED; cnt_en_d = 1'b1;     walk_d = 1'b1; end
      LOAD_G:  begin light_d = LAMP_GRN; cnt_init_d = 3'b001; end
      GREEN:   begin light_d = LAMP_GRN; cnt_en_d = 1'b1; end
      LOAD_Y:  begin light_d = LAMP_YEL; cnt_init_d = 3'b010; end
      YELLOW:  begin light_d = LAMP_YEL; cnt_en_d = 1'b1; end
      FLASH:   light_d = flash_ph_d ? LAMP_OFF : LAMP_YEL;
      default: light_d = LAMP_RED;
    endcase

    // Requests are ignored while walking or flashing; a request in the same
    // cycle as the move to LOAD_R is lost because the clear wins.
    if ((bus_if.ped_req) && (state_q != LOAD_R) && (state_q != RED) && (state_q != FLASH))
      pend_d = 1'b1;
    if (((state_d == LOAD_R) && (state_q != LOAD_R)) ||
        ((state_d == FLASH)  && (state_q != FLASH)))
      pend_d = 1'b0;
  end

  // State and output registers with asynchronous reset to the IDLE outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_init_q  <= 3'b000;
      cnt_en_q    <= 1'b0;
      light_q     <= LAMP_RED;
      walk_q      <= 1'b0;
      pend_q      <= 1'b0;
      flash_cnt_q <= 8'd0;
      flash_ph_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_init_q  <= cnt_init_d;
      cnt_en_q    <= cnt_en_d;
      light_q     <= light_d;
      walk_q      <= walk_d;
      pend_q      <= pend_d;
      flash_cnt_q <= flash_cnt_d;
      flash_ph_q  <= flash_ph_d;
    end
  end

  assign bus_if.cnt_init  = cnt_init_q;
  assign bus_if.cnt_en    = cnt_en_q;
  assign bus_if.light_out = light_q;
  assign bus_if.ped_walk  = walk_q;
  assign bus_if.ped_pend  = pend_q;

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Moore FSM that sequences one light_counter instance through RED -> GREEN -> YELLOW -> RED.
- Issues one-cycle one-hot load pulses, gates the counter enable, and drives the lamp and pedestrian-walk outputs.
- Adds latched pedestrian-request green shortening and a flashing-yellow maintenance mode.
- Sits between the intersection top level and light_counter.

Parameters:
- pCNT_WIDTH, 5, width of cnt_val; must match the counter.
- pPED_MIN_GREEN, 4, minimum remaining green count; a pedestrian request cuts green only while cnt_val > this value.
- pFLASH_HALF, 4, cycles per half-period of the flashing yellow, range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  1 = normal cycling, 0 = flashing-yellow mode.
- ped_req  in  1  pedestrian request, level or pulse; sampled every cycle.
- cnt_last  in  1  counter at zero.
- cnt_val  in  pCNT_WIDTH  current counter value.
- cnt_init  out  3  one-hot load pulse to counter: 001 green, 010 yellow, 100 red.
- cnt_en  out  1  counter decrement enable.
- light_out  out  3  lamps: [2] red, [1] yellow, [0] green.
- ped_walk  out  1  walk signal.
- ped_pend  out  1  pedestrian request pending.

Behaviour:
- Outputs: all registered; every output changes only on a clk edge.
- Counter contract: on an init pulse, the counter loads its INIT value. With cnt_en=1 it decrements. cnt_last=1 iff the value is 0.
- Reset (rst=1): asynchronous; takes effect immediately.
  - state=IDLE, light_out=100, cnt_init=000, cnt_en=0, ped_walk=0, ped_pend=0, flash counter=0.
- States: IDLE, LOAD_R, RED, LOAD_G, GREEN, LOAD_Y, YELLOW, FLASH.
- IDLE: next state is LOAD_R if run=1, else FLASH.
- LOAD_x states:
  - cnt_init = one-hot of x for exactly 1 cycle; cnt_en=0.
  - light_out = lamp of x.
  - cnt_last is ignored (it is stale from the previous phase).
  - Next state is the matching run state.
- Run states RED/GREEN/YELLOW:
  - cnt_init=000, cnt_en=1, light_out = phase lamp.
  - On cnt_last=1: RED->LOAD_G, GREEN->LOAD_Y, YELLOW->LOAD_R.
  - Visible phase length = INIT+2 cycles (1 load cycle + INIT+1 counting cycles).
- Pedestrian request:
  - ped_pend is set by ped_req=1 in any state except LOAD_R, RED, FLASH; ped_req is ignored in those states.
  - ped_pend is cleared on entry to LOAD_R and on entry to FLASH.
  - In GREEN with ped_pend=1 and cnt_val > pPED_MIN_GREEN: next state LOAD_Y, without waiting for cnt_last.
  - Otherwise GREEN runs to cnt_last.
  - Yellow is never shortened.
- ped_walk = 1 exactly in LOAD_R and RED.
- Flash mode:
  - run=0 in any non-FLASH state: next state FLASH; this overrides all other transitions.
  - In FLASH: cnt_en=0, cnt_init=000, ped_walk=0.
  - light_out alternates 010 / 000. Each level is held for pFLASH_HALF cycles, starting with 010 on the first FLASH cycle.
  - The flash counter resets to 0 on FLASH entry.
  - run=1 in FLASH: next state LOAD_R (safe re-entry always via red).
- Simultaneous events:
  - run=0 beats cnt_last and ped shortening.
  - cnt_last=1 and a ped shortening condition in the same GREEN cycle both go to LOAD_Y (identical result).
  - ped_req arriving in the same cycle as the LOAD_R transition is dropped.
- Mid-operation reset: rst asserted at any point returns to IDLE outputs asynchronously. On release, sequencing restarts from LOAD_R (run=1).
- cnt_init is never nonzero in two consecutive cycles. cnt_en and cnt_init are never both active.

Test Plan:
- Normal cycle. Counter with G=14, Y=2, R=17; release rst with run=1.
  - Required: LOAD_R pulse cnt_init=100 on the first cycle, then red 19 cycles total with ped_walk=1.
  - Then green 16 cycles, yellow 4 cycles, then red again.
  - cnt_init pulses exactly 1 cycle each.
- Pedestrian shortening. Pulse ped_req while GREEN with cnt_val=10 (>4).
  - Required: ped_pend=1 next cycle; next cycle LOAD_Y (cnt_init=010); ped_pend clears at LOAD_R; ped_walk=1 through RED.
- Late request. ped_req while GREEN with cnt_val=3.
  - Required: green runs to cnt_last; yellow follows normally; ped_pend stays 1 until LOAD_R.
- Request during red. ped_req held high through RED.
  - Required: ped_pend stays 0; the next green is full length (16 cycles).
- Flash mode. Drop run to 0 mid-GREEN.
  - Required: next cycle light_out=010 for 4 cycles, 000 for 4, repeating; cnt_en=0.
  - Raise run: LOAD_R with cnt_init=100, then normal red.
- Reset mid-YELLOW. Assert rst between edges.
  - Required: light_out=100, cnt_en=0, ped_pend=0 immediately (asynchronous, before next edge); after release, LOAD_R.
